ps2_host_transmitter: RTL and testbench
=======================================

Name: ps2_host_transmitter

Overview:
- Host-to-device PS/2 sender: transmits one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over open-drain kclk/kdata.
- Sits beside the existing PS/2 receive path on the same pins.
- Runs the inhibit / request-to-send sequence, shifts data, parity and stop on device-generated clock, and checks the device ack.
- `busy` tells the receive path to discard line activity while a host frame is in progress.

Parameters:
- INHIBIT_CYCLES, 10000, clk cycles kclk is held low before request (100 us at 100 MHz)
- FILTER_COUNT, 19, consecutive stable samples needed before a filtered line changes
- START_TIMEOUT, 1500000, clk cycles allowed from request to first device falling edge (15 ms)
- XFER_TIMEOUT, 200000, clk cycles allowed from first falling edge to ack complete (2 ms)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- kclk  in  1  raw PS/2 clock line (pin readback)
- kdata  in  1  raw PS/2 data line (pin readback)
- kclk_drive_low  out  1  1 = pull kclk low, 0 = release (tristate at top level)
- kdata_drive_low  out  1  1 = pull kdata low, 0 = release
- tx_data  in  8  byte to send
- tx_valid  in  1  request; accepted on the cycle where tx_valid & tx_ready
- tx_ready  out  1  high only in IDLE
- busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse: frame sent, ack received, lines idle
- tx_ack_err  out  1  one-cycle pulse: device did not ack (kdata high at 11th falling edge)
- tx_timeout  out  1  one-cycle pulse: START_TIMEOUT or XFER_TIMEOUT expired

Behaviour:
- Reset values:
  - All outputs are 0, including tx_ready.
  - State is IDLE; both lines are released.
  - tx_ready rises on the first clock after rst_n goes high.
- Line inputs:
  - Each line passes through a 2-FF synchronizer, then the filter.
  - The filtered value changes only after FILTER_COUNT consecutive identical samples.
  - A device falling edge is filtered kclk going 1 to 0, registered; it is a one-cycle event.
- Accept:
  - On tx_valid & tx_ready, latch tx_data and latch parity = ~^tx_data (odd).
  - Go to INHIBIT on the next cycle. tx_ready drops the same edge.
  - tx_valid outside IDLE is ignored; no queueing.
- INHIBIT:
  - kclk_drive_low = 1 for INHIBIT_CYCLES cycles.
  - kdata_drive_low = 1 from the last cycle of INHIBIT onward (start bit).
  - Any device frame in progress is aborted; this is standard PS/2.
- REQUEST:
  - kclk released, kdata held low.
  - Clear timer; wait for a device falling edge.
  - START_TIMEOUT expiry: pulse tx_timeout, release both lines, go to IDLE.
- SHIFT:
  - Falling edges 1..8 drive data bits d0..d7, LSB first. Drive low when the bit is 0, release when 1.
  - Falling edge 9 drives parity.
  - Falling edge 10 releases kdata (stop bit).
  - The drive value updates the cycle after the edge event.
  - The bit counter is 4 bits and saturates; it never wraps.
- ACK: at falling edge 11, sample filtered kdata.
  - 0: ack OK.
  - 1: pulse tx_ack_err, release lines, go to IDLE (no tx_done).
- WAIT_IDLE: wait until filtered kclk and kdata are both 1, then pulse tx_done and go to IDLE.
- XFER_TIMEOUT:
  - The timer restarts at falling edge 1 and covers SHIFT, ACK and WAIT_IDLE.
  - On expiry: pulse tx_timeout, release lines, go to IDLE.
  - Pulses are mutually exclusive; timeout takes priority over an event in the same cycle.
- rst_n low mid-frame: both drive outputs are 0 on the next edge, all pulses are suppressed, state is IDLE.
- The module never drives a line high. Release is the only way a 1 appears on the pins.

Decomposition:
- Shared package ps2_pkg holds:
  - state enum {IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE}
  - PS2_DATA_BITS = 8
  - PS2_FRAME_EDGES = 11
  - PS2 command constants CMD_SET_LEDS = 8'hED, CMD_RESET = 8'hFF, RESP_ACK = 8'hFA
- One sub-module, ps2_line_filter, instantiated twice. It contains the synchronizer plus the stable-count filter, with a FILTER_COUNT parameter.

Test Plan:
- Run the bench with FILTER_COUNT=3, INHIBIT_CYCLES=50, START_TIMEOUT=5000, XFER_TIMEOUT=20000; the device model clock period is 200 cycles.
- Send 0xED, device acks -> kclk low exactly 50 cycles; bits at edges 1..10 = 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done once; busy high from accept to tx_done.
- Send 0xFF, device acks -> eight 1s, parity 0 (kdata low at edge 9), tx_done.
- Send 0x00, device leaves kdata high at edge 11 -> tx_ack_err pulse, no tx_done, both drive outputs 0 next cycle.
- Send 0x55, device never clocks -> tx_timeout exactly START_TIMEOUT cycles after REQUEST entry; lines released; tx_ready 1.
- tx_valid held high with 0x11 then 0x22 during the 0x11 frame -> only 0x11 sent; rst_n low at edge 5 -> drives 0 next cycle, no pulses; 0x22 accepted after reset.
- Glitch on kclk shorter than FILTER_COUNT during SHIFT -> no extra bit advance; frame bits unchanged.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmit FSM states, frame geometry and
// common keyboard command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam int PS2_DATA_BITS   = 8;
    localparam int PS2_FRAME_EDGES = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a stable-count filter for one PS/2 line.
// The filtered output only follows the pin after FILTER_COUNT agreeing samples.
module ps2_line_filter #(
    parameter int FILTER_COUNT = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic line_o
);

    localparam int CW = (FILTER_COUNT > 1) ? $clog2(FILTER_COUNT) : 1;

    logic [1:0]    sync_q;
    logic          filt_q;
    logic [CW-1:0] cnt_q;

    // Idle PS/2 lines are pulled high, so reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            if (sync_q[1] != filt_q) begin
                if (cnt_q == CW'(FILTER_COUNT - 1)) begin
                    filt_q <= sync_q[1];
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command sender: inhibit, request-to-send, shift the byte
// on device clock edges, check the device ack, then wait for idle lines.
module ps2_host_transmitter
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int FILTER_COUNT   = 19,
    parameter int START_TIMEOUT  = 1500000,
    parameter int XFER_TIMEOUT   = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kclk,
    input  logic       kdata,
    output logic       kclk_drive_low,
    output logic       kdata_drive_low,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout
);

    ps2_state_e               state_q, state_d;
    logic [31:0]              timer_q, timer_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d, bit_inc;
    logic [PS2_DATA_BITS-1:0] data_q, data_d;
    logic                     parity_q, parity_d;
    logic                     kclk_drv_q, kclk_drv_d;
    logic                     kdata_drv_q, kdata_drv_d;
    logic                     done_q, done_d;
    logic                     ack_err_q, ack_err_d;
    logic                     timeout_q, timeout_d;
    logic                     tx_ready_q, busy_q;
    logic                     kclk_f, kdata_f;
    logic                     kclk_f_prev_q, kclk_fall_q;

    ps2_line_filter #(.FILTER_COUNT(FILTER_COUNT)) u_kclk_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (kclk),
        .line_o (kclk_f)
    );

    ps2_line_filter #(.FILTER_COUNT(FILTER_COUNT)) u_kdata_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (kdata),
        .line_o (kdata_f)
    );

    assign bit_inc = (bit_cnt_q == 4'hF) ? bit_cnt_q : bit_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 32'd1;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        parity_d    = parity_q;
        kclk_drv_d  = 1'b0;
        kdata_drv_d = kdata_drv_q;
        done_d      = 1'b0;
        ack_err_d   = 1'b0;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                timer_d     = '0;
                kdata_drv_d = 1'b0;
                if (tx_valid && tx_ready_q) begin
                    data_d      = tx_data;
                    parity_d    = odd_parity(tx_data);
                    bit_cnt_d   = '0;
                    state_d     = INHIBIT;
                    kclk_drv_d  = 1'b1;
                    kdata_drv_d = (INHIBIT_CYCLES == 1);
                end
            end
            INHIBIT: begin
                kclk_drv_d = 1'b1;
                if (timer_q == 32'(INHIBIT_CYCLES - 1)) begin
                    state_d     = REQUEST;
                    timer_d     = '0;
                    kclk_drv_d  = 1'b0;
                    kdata_drv_d = 1'b1;
                end else begin
                    // Start bit goes down on the final inhibit cycle.
                    kdata_drv_d = (timer_d == 32'(INHIBIT_CYCLES - 1));
                end
            end
            REQUEST: begin
                kdata_drv_d = 1'b1;
                if (timer_q == 32'(START_TIMEOUT - 1)) begin
                    timeout_d   = 1'b1;
                    state_d     = IDLE;
                    kdata_drv_d = 1'b0;
                end else if (kclk_fall_q) begin
                    state_d     = SHIFT;
                    timer_d     = '0;
                    bit_cnt_d   = 4'd1;
                    kdata_drv_d = ~data_q[0];
                end
            end
            SHIFT: begin
                if (timer_q == 32'(XFER_TIMEOUT - 1)) begin
                    timeout_d   = 1'b1;
                    state_d     = IDLE;
                    kdata_drv_d = 1'b0;
                end else if (kclk_fall_q) begin
                    bit_cnt_d = bit_inc;
                    if (bit_cnt_q < 4'(PS2_DATA_BITS)) begin
                        kdata_drv_d = ~data_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'(PS2_DATA_BITS)) begin
                        kdata_drv_d = ~parity_q;
                    end else begin
                        kdata_drv_d = 1'b0;
                        state_d     = ACK;
                    end
                end
            end
            ACK: begin
                kdata_drv_d = 1'b0;
                if (timer_q == 32'(XFER_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (kclk_fall_q) begin
                    bit_cnt_d = bit_inc;
                    if (kdata_f) begin
                        ack_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                kdata_drv_d = 1'b0;
                if (timer_q == 32'(XFER_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (kclk_f && kdata_f) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                kdata_drv_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            bit_cnt_q     <= '0;
            data_q        <= '0;
            parity_q      <= 1'b0;
            kclk_drv_q    <= 1'b0;
            kdata_drv_q   <= 1'b0;
            done_q        <= 1'b0;
            ack_err_q     <= 1'b0;
            timeout_q     <= 1'b0;
            tx_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            kclk_f_prev_q <= 1'b1;
            kclk_fall_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            bit_cnt_q     <= bit_cnt_d;
            data_q        <= data_d;
            parity_q      <= parity_d;
            kclk_drv_q    <= kclk_drv_d;
            kdata_drv_q   <= kdata_drv_d;
            done_q        <= done_d;
            ack_err_q     <= ack_err_d;
            timeout_q     <= timeout_d;
            tx_ready_q    <= (state_d == IDLE);
            busy_q        <= (state_d != IDLE);
            kclk_f_prev_q <= kclk_f;
            kclk_fall_q   <= kclk_f_prev_q & ~kclk_f;
        end
    end

    assign kclk_drive_low  = kclk_drv_q;
    assign kdata_drive_low = kdata_drv_q;
    assign tx_ready        = tx_ready_q;
    assign busy            = busy_q;
    assign tx_done         = done_q;
    assign tx_ack_err      = ack_err_q;
    assign tx_timeout      = timeout_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: a PS/2 device model clocks frames out of the
// host and the captured bits are compared with a byte-level frame model.
module tb_ps2_host_transmitter;
    import ps2_pkg::*;

    localparam int FC  = 3;
    localparam int INH = 50;
    localparam int STO = 5000;
    localparam int XTO = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dev_kclk = 1'b1;
    logic       dev_kdata = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       kclk_drive_low, kdata_drive_low;
    logic       tx_ready, busy, tx_done, tx_ack_err, tx_timeout;
    logic       kclk, kdata;

    // Open-drain wired-AND of host and device.
    assign kclk  = ~kclk_drive_low & dev_kclk;
    assign kdata = ~kdata_drive_low & dev_kdata;

    always #5 clk = ~clk;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES (INH),
        .FILTER_COUNT   (FC),
        .START_TIMEOUT  (STO),
        .XFER_TIMEOUT   (XTO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .kclk            (kclk),
        .kdata           (kdata),
        .kclk_drive_low  (kclk_drive_low),
        .kdata_drive_low (kdata_drive_low),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .busy            (busy),
        .tx_done         (tx_done),
        .tx_ack_err      (tx_ack_err),
        .tx_timeout      (tx_timeout)
    );

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0, done_cnt = 0, err_cnt = 0, to_cnt = 0, multi_cnt = 0;
    int acc_cnt = 0, acc_seen = 0, busy_low = 0;
    int kclk_low_run = 0, kclk_low_len = 0, kclk_rel_cyc = 0, kdata_rise_cyc = 0, to_cyc = 0;
    logic prev_kclk_drv = 1'b0, prev_kdata_drv = 1'b0;
    bit frame_active = 1'b0;

    always @(posedge clk) begin
        if (rst_n && tx_valid && tx_ready) acc_cnt++;
    end

    always @(negedge clk) begin
        cyc++;
        if (tx_done) done_cnt++;
        if (tx_ack_err) err_cnt++;
        if (tx_timeout) begin to_cnt++; to_cyc = cyc; end
        if (int'(tx_done) + int'(tx_ack_err) + int'(tx_timeout) > 1) multi_cnt++;
        if (kclk_drive_low) kclk_low_run++;
        else if (prev_kclk_drv) begin
            kclk_low_len = kclk_low_run;
            kclk_low_run = 0;
            kclk_rel_cyc = cyc;
        end
        if (kdata_drive_low && !prev_kdata_drv && kclk_drive_low) kdata_rise_cyc = cyc;
        if (!rst_n || tx_done || tx_ack_err || tx_timeout) frame_active = 1'b0;
        if (acc_cnt != acc_seen) begin frame_active = 1'b1; acc_seen = acc_cnt; end
        if (frame_active && !busy) busy_low++;
        prev_kclk_drv  = kclk_drive_low;
        prev_kdata_drv = kdata_drive_low;
    end

    // Frame as it should appear on kdata at falling edges 1..10.
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        ref_frame[7:0] = b;
        ref_frame[8]   = (ones % 2 == 0);
        ref_frame[9]   = 1'b1;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (tx_ready) ok = 1'b1;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL send_ready: tx_ready=%0b required=1", tx_ready);
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic dev_frame(input int n_edges, input bit ack, input int glitch_k,
                             output logic [9:0] bits);
        bit found = 1'b0;
        bits = '0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (kclk && !kdata && !kclk_drive_low) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL dev_request: request seen=0 required=1");
            return;
        end
        repeat (50) @(negedge clk);
        for (int k = 1; k <= n_edges; k++) begin
            dev_kclk = 1'b0;
            repeat (90) @(negedge clk);
            if (k <= 10) bits[k-1] = kdata;
            repeat (10) @(negedge clk);
            dev_kclk = 1'b1;
            repeat (50) @(negedge clk);
            if (k == glitch_k) begin
                dev_kclk = 1'b0;
                repeat (FC - 1) @(negedge clk);
                dev_kclk = 1'b1;
            end
            if (k == 10 && ack) dev_kdata = 1'b0;
            repeat (50) @(negedge clk);
        end
        if (n_edges == 11) dev_kdata = 1'b1;
    endtask

    task automatic wait_pulse(input int limit, output bit seen);
        int base = done_cnt + err_cnt + to_cnt;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done_cnt + err_cnt + to_cnt != base) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({kclk_drive_low, kdata_drive_low, tx_ready, busy, tx_done, tx_ack_err, tx_timeout} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {kclk_drive_low, kdata_drive_low, tx_ready, busy, tx_done, tx_ack_err, tx_timeout});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_rise: tx_ready=%b required=1", tx_ready);
        end
    endtask

    task automatic test_frame(input string name, input logic [7:0] b, input bit ack, input int glitch_k);
        logic [9:0] bits;
        logic [9:0] exp_bits = ref_frame(b);
        int d0 = done_cnt, e0 = err_cnt, t0 = to_cnt, bl0 = busy_low;
        bit seen;
        send_byte(b);
        dev_frame(11, ack, glitch_k, bits);
        wait_pulse(500, seen);
        n_cmp++;
        if (bits !== exp_bits) begin
            n_err++;
            $display("FAIL %s bits: got %b required %b (edge10..edge1)", name, bits, exp_bits);
        end
        n_cmp++;
        if (done_cnt - d0 != int'(ack) || err_cnt - e0 != int'(!ack) || to_cnt - t0 != 0) begin
            n_err++;
            $display("FAIL %s pulses: done/err/to=%0d/%0d/%0d required %0d/%0d/0",
                     name, done_cnt - d0, err_cnt - e0, to_cnt - t0, int'(ack), int'(!ack));
        end
        n_cmp++;
        if (kclk_low_len != INH) begin
            n_err++;
            $display("FAIL %s inhibit_len: got %0d required %0d", name, kclk_low_len, INH);
        end
        n_cmp++;
        if (kdata_rise_cyc != kclk_rel_cyc - 1) begin
            n_err++;
            $display("FAIL %s start_bit: kdata low at %0d required %0d", name, kdata_rise_cyc, kclk_rel_cyc - 1);
        end
        n_cmp++;
        if (busy_low != bl0) begin
            n_err++;
            $display("FAIL %s busy: low for %0d cycles in frame required 0", name, busy_low - bl0);
        end
        @(negedge clk);
        n_cmp++;
        if ({kclk_drive_low, kdata_drive_low, tx_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL %s after: kclk_drv/kdata_drv/ready=%b required 001",
                     name, {kclk_drive_low, kdata_drive_low, tx_ready});
        end
    endtask

    task automatic test_start_timeout();
        int d0 = done_cnt, e0 = err_cnt, t0 = to_cnt;
        bit seen;
        send_byte(8'h55);
        wait_pulse(STO + INH + 500, seen);
        n_cmp++;
        if (to_cnt - t0 != 1 || done_cnt != d0 || err_cnt != e0) begin
            n_err++;
            $display("FAIL start_timeout pulses: to/done/err=%0d/%0d/%0d required 1/0/0",
                     to_cnt - t0, done_cnt - d0, err_cnt - e0);
        end
        n_cmp++;
        if (to_cyc - kclk_rel_cyc != STO) begin
            n_err++;
            $display("FAIL start_timeout latency: got %0d required %0d", to_cyc - kclk_rel_cyc, STO);
        end
        @(negedge clk);
        n_cmp++;
        if ({kclk_drive_low, kdata_drive_low, tx_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL start_timeout after: kclk_drv/kdata_drv/ready=%b required 001",
                     {kclk_drive_low, kdata_drive_low, tx_ready});
        end
    endtask

    task automatic test_back_to_back_reset();
        logic [9:0] bits;
        logic [9:0] exp_first = ref_frame(8'h11);
        int a0 = acc_cnt, p0;
        bit ok = 1'b0;
        @(negedge clk);
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (acc_cnt != a0) ok = 1'b1;
        end
        tx_data = 8'h22;
        dev_frame(4, 1'b0, 0, bits);
        n_cmp++;
        if (bits[3:0] !== exp_first[3:0] || acc_cnt - a0 != 1) begin
            n_err++;
            $display("FAIL b2b_first: bits=%b accepts=%0d required %b and 1", bits[3:0], acc_cnt - a0, exp_first[3:0]);
        end
        dev_kclk = 1'b0;
        repeat (20) @(negedge clk);
        p0 = done_cnt + err_cnt + to_cnt;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({kclk_drive_low, kdata_drive_low} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_midframe drives: got %b required 00", {kclk_drive_low, kdata_drive_low});
        end
        dev_kclk = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        a0 = acc_cnt;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (acc_cnt != a0) ok = 1'b1;
        end
        tx_valid = 1'b0;
        n_cmp++;
        if (done_cnt + err_cnt + to_cnt != p0) begin
            n_err++;
            $display("FAIL reset_midframe pulses: got %0d required 0", done_cnt + err_cnt + to_cnt - p0);
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL b2b_second_accept: accepted=0 required=1");
        end
        dev_frame(11, 1'b1, 0, bits);
        wait_pulse(500, ok);
        n_cmp++;
        if (bits !== ref_frame(8'h22) || !ok || acc_cnt - a0 != 1) begin
            n_err++;
            $display("FAIL b2b_second: bits=%b pulse=%0b accepts=%0d required %b 1 1",
                     bits, ok, acc_cnt - a0, ref_frame(8'h22));
        end
    endtask

    initial begin
        test_reset();
        test_frame("set_leds", CMD_SET_LEDS, 1'b1, 0);
        test_frame("reset_cmd", CMD_RESET, 1'b1, 0);
        test_frame("no_ack", 8'h00, 1'b0, 0);
        test_start_timeout();
        test_back_to_back_reset();
        test_frame("glitch", 8'($urandom_range(0, 255)), 1'b1, int'($urandom_range(2, 8)));
        for (int i = 0; i < 4; i++) begin
            test_frame("random", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);
        end
        n_cmp++;
        if (multi_cnt != 0) begin
            n_err++;
            $display("FAIL pulse_exclusive: overlapping cycles=%0d required 0", multi_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
